// File: rtl/eth_pcs_pkg.sv
// Shared 40GBASE-R PCS definitions: sync headers, alignment-marker patterns and
// marker cadence default, used by both the TX alignment generator and RX lock.
package eth_pcs_pkg;

  typedef enum logic [1:0] {
    S_CTRL = 2'b01,
    S_DATA = 2'b10
  } sync_hdr_e;

  // Marker bytes M0..M2; M4..M6 on the wire are their bitwise complements.
  typedef struct packed {
    logic [7:0] m0;
    logic [7:0] m1;
    logic [7:0] m2;
  } am_pattern_t;

  localparam am_pattern_t AM_LANE_PATTERN [4] = '{
    '{m0: 8'h90, m1: 8'h76, m2: 8'h47},
    '{m0: 8'hF0, m1: 8'hC4, m2: 8'hE6},
    '{m0: 8'hC5, m1: 8'h65, m2: 8'h9B},
    '{m0: 8'hA2, m1: 8'h79, m2: 8'h3D}
  };

  localparam int AM_INTERVAL_DEFAULT = 16384;

  typedef enum logic [1:0] {
    AM_FIND    = 2'd0,
    AM_CONFIRM = 2'd1,
    AM_LOCKED  = 2'd2
  } am_state_e;

endpackage

// File: rtl/am_matcher.sv
// Combinational alignment-marker detector: reports whether a 66-bit block is a
// marker for any of the four logical lanes, and which one.
module am_matcher
  import eth_pcs_pkg::*;
(
  input  logic [65:0] block_in,
  output logic        hit,
  output logic [1:0]  hit_lane
);

  am_pattern_t rx_pat;
  am_pattern_t rx_pat_inv;
  logic        unused_bip;

  assign rx_pat     = '{m0: block_in[9:2],   m1: block_in[17:10], m2: block_in[25:18]};
  assign rx_pat_inv = '{m0: block_in[41:34], m1: block_in[49:42], m2: block_in[57:50]};
  // BIP bytes carry per-period parity and never take part in matching.
  assign unused_bip = ^{block_in[65:58], block_in[33:26]};

  always_comb begin
    hit      = 1'b0;
    hit_lane = 2'd0;
    if (block_in[1:0] == S_CTRL) begin
      for (int l = 0; l < 4; l++) begin
        if (rx_pat == AM_LANE_PATTERN[l] && rx_pat_inv == ~AM_LANE_PATTERN[l]) begin
          hit      = 1'b1;
          hit_lane = 2'(l);
        end
      end
    end
  end

endmodule

// File: rtl/am_lock.sv
// Per-lane RX alignment-marker lock: finds markers, confirms their cadence,
// reports lock plus logical lane ID, and flags marker blocks one cycle later.
module am_lock
  import eth_pcs_pkg::*;
#(
  parameter int AM_INTERVAL      = AM_INTERVAL_DEFAULT,
  parameter int AM_INVALID_LIMIT = 4
) (
  input  logic        core_clk,
  input  logic        core_reset,
  input  logic        block_locked,
  input  logic        block_valid,
  input  logic [65:0] block_in,
  output logic [65:0] block_out,
  output logic        block_out_valid,
  output logic        am_strobe,
  output logic        am_locked,
  output logic [1:0]  lane_id
);

  localparam int CW = $clog2(AM_INTERVAL);
  localparam int IW = $clog2(AM_INVALID_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(AM_INTERVAL - 1);
  localparam logic [IW-1:0] INVLD_MAX = IW'(AM_INVALID_LIMIT);

  am_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] invld_q, invld_d, invld_inc;
  logic [1:0]  cand_q, cand_d;
  logic [1:0]  lane_id_q, lane_id_d;
  logic        am_locked_q, am_locked_d;
  logic        am_strobe_q, am_strobe_d;
  logic        bov_q, bov_d;
  logic [65:0] block_out_q, block_out_d;
  logic        hit;
  logic [1:0]  hit_lane;
  logic        at_expected;

  am_matcher u_matcher (
    .block_in (block_in),
    .hit      (hit),
    .hit_lane (hit_lane)
  );

  assign at_expected = (cnt_q == CNT_LAST);
  assign invld_inc   = invld_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    invld_d     = invld_q;
    cand_d      = cand_q;
    lane_id_d   = lane_id_q;
    am_locked_d = am_locked_q;
    am_strobe_d = 1'b0;
    bov_d       = block_valid & block_locked;
    block_out_d = block_in;

    // Losing block lock dominates everything, including a marker hit.
    if (!block_locked) begin
      state_d     = AM_FIND;
      cnt_d       = '0;
      invld_d     = '0;
      am_locked_d = 1'b0;
      lane_id_d   = 2'd0;
    end else if (block_valid) begin
      case (state_q)
        AM_FIND: begin
          cnt_d = '0;
          if (hit) begin
            cand_d      = hit_lane;
            am_strobe_d = 1'b1;
            state_d     = AM_CONFIRM;
          end
        end
        AM_CONFIRM: begin
          if (at_expected) begin
            cnt_d = '0;
            if (hit && hit_lane == cand_q) begin
              state_d     = AM_LOCKED;
              am_locked_d = 1'b1;
              lane_id_d   = cand_q;
              am_strobe_d = 1'b1;
              invld_d     = '0;
            end else begin
              state_d = AM_FIND;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        AM_LOCKED: begin
          if (at_expected) begin
            cnt_d       = '0;
            am_strobe_d = 1'b1;
            if (hit && hit_lane == lane_id_q) begin
              invld_d = '0;
            end else if (invld_inc == INVLD_MAX) begin
              state_d     = AM_FIND;
              am_locked_d = 1'b0;
              lane_id_d   = 2'd0;
              invld_d     = '0;
            end else begin
              invld_d = invld_inc;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = AM_FIND;
      endcase
    end
  end

  always_ff @(posedge core_clk or posedge core_reset) begin
    if (core_reset) begin
      state_q     <= AM_FIND;
      cnt_q       <= '0;
      invld_q     <= '0;
      cand_q      <= 2'd0;
      lane_id_q   <= 2'd0;
      am_locked_q <= 1'b0;
      am_strobe_q <= 1'b0;
      bov_q       <= 1'b0;
      block_out_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      invld_q     <= invld_d;
      cand_q      <= cand_d;
      lane_id_q   <= lane_id_d;
      am_locked_q <= am_locked_d;
      am_strobe_q <= am_strobe_d;
      bov_q       <= bov_d;
      block_out_q <= block_out_d;
    end
  end

  assign block_out       = block_out_q;
  assign block_out_valid = bov_q;
  assign am_strobe       = am_strobe_q;
  assign am_locked       = am_locked_q;
  assign lane_id         = lane_id_q;

endmodule
